ethernet_rx_drain: RTL and testbench
====================================

ETHERNET_RX_DRAIN -- requirements
Module: ethernet_rx_drain

Interface
REQ-001 SHALL have parameter data_width_p, default 64, stream/buffer word width in bits (32 or 64).
REQ-002 SHALL have parameter buf_size_p, default 2048, receive buffer size in bytes; addr_width_lp = $clog2(buf_size_p).
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_ready_i  input  1  receiver holds a complete packet.
REQ-006 SHALL have port rx_packet_size_i  input  16  packet byte count, valid while rx_ready_i.
REQ-007 SHALL have ports buffer_read_v_o output 1, buffer_read_addr_o output addr_width_lp (byte address), buffer_read_op_size_o output 2 (constant log2(data_width_p/8)), buffer_read_data_i input data_width_p.
REQ-008 SHALL have port clear_buffer_o  output  1  one-cycle pulse releasing the packet slot.
REQ-009 SHALL have ports m_axis_tdata_o output data_width_p, m_axis_tkeep_o output data_width_p/8, m_axis_tvalid_o output 1, m_axis_tready_i input 1, m_axis_tlast_o output 1.
REQ-010 SHALL have port packet_count_o  output  16  packets fully streamed, wraps at 0xFFFF->0.

Function
REQ-011 SHALL implement FSM states IDLE, READ, DRAIN, CLEAR.
REQ-012 IDLE: on rx_ready_i=1, latch size, words = ceil(size/(data_width_p/8)), addr=0; go READ (go CLEAR if size=0).
REQ-013 Buffer read data SHALL be taken as valid exactly one cycle after buffer_read_v_o.
REQ-014 READ: issue buffer_read_v_o only when output FIFO occupancy plus in-flight reads < 2; address increments by data_width_p/8 per issued read.
REQ-015 After the last word read is issued, SHALL go DRAIN; no further reads in DRAIN.
REQ-016 Output FIFO SHALL be 2 entries; a full FIFO with m_axis_tready_i=0 holds m_axis_* stable; no beat lost or duplicated.
REQ-017 Beats SHALL carry tkeep all-ones except the last beat, whose tkeep has the low (size mod bytes_per_word) bits set, all-ones if remainder 0; tlast=1 only on the last beat.
REQ-018 Full-throughput: with m_axis_tready_i held 1, one beat per cycle after a 2-cycle startup (IDLE->READ, read latency).
REQ-019 DRAIN: on last-beat handshake (tvalid&tready&tlast) go CLEAR and increment packet_count_o.
REQ-020 CLEAR: assert clear_buffer_o for exactly one cycle, then IDLE; rx_ready_i is not sampled in CLEAR.
REQ-021 rx_ready_i dropping mid-packet is illegal; a simulation-only assertion SHALL flag it.
REQ-022 Sizes above buf_size_p SHALL be clamped to buf_size_p.

Reset
REQ-023 On reset_i: state IDLE, FIFO empty, in-flight cleared, buffer_read_v_o=0, clear_buffer_o=0, m_axis_tvalid_o=0, m_axis_tlast_o=0, tdata/tkeep=0, packet_count_o=0.
REQ-024 Reset asserted mid-packet SHALL abandon the packet without a clear_buffer_o pulse.

Configuration
REQ-025 Macro ETHERNET_RX_DRAIN_RUNT_DROP_EN: when defined, packets with size < 60 SHALL go IDLE->CLEAR directly (no beats, packet_count_o unchanged) and a 16-bit wrapping output runt_count_o SHALL count them; when undefined, all non-zero packets are streamed and runt_count_o is absent.

Structure
REQ-026 Shared package SHALL hold the FSM state enum, the 60-byte runt threshold constant and the bytes-per-word helper.
REQ-027 Output FIFO SHALL be a sub-module named ethernet_rx_drain_fifo (2-entry, valid/ready both sides).

Verification
REQ-028 Size 64, tready=1 -> 8 beats on consecutive cycles, last tkeep=0xFF, one clear pulse, packet_count_o=1.
REQ-029 Size 61 -> 8 beats, last tkeep=0x1F, tlast on beat 8 only.
REQ-030 Size 128, tready toggling 1/0 each cycle -> 16 beats in order, data matches buffer, no read issued with FIFO full.
REQ-031 Size 0 -> no beats, clear_buffer_o pulse 1 cycle after rx_ready_i seen, packet_count_o unchanged.
REQ-032 Reset asserted during beat 3 of 64-byte packet -> all outputs return to reset values, no clear pulse, next packet streams correctly.
REQ-033 With ETHERNET_RX_DRAIN_RUNT_DROP_EN, size 40 -> no beats, clear pulse, runt_count_o=1, packet_count_o=0.

Source files
------------

// File: rtl/ethernet_rx_drain_pkg.sv
// Shared definitions for the receive-buffer drain engine.
//   state_e        : drain FSM states
//   RUNT_BYTES     : packets shorter than this count as runts
//   bytes_per_word : bytes carried by one stream/buffer word
package ethernet_rx_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  localparam int unsigned RUNT_BYTES = 60;

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ethernet_rx_drain_if.sv
// AXI-Stream style beat interface carrying drained packet data.
//   tdata/tkeep/tlast/tvalid : driven by master
//   tready                   : driven by slave
interface ethernet_rx_drain_if #(
  parameter int unsigned data_width_p = 64
) ();
  logic [data_width_p-1:0]   tdata;
  logic [data_width_p/8-1:0] tkeep;
  logic                      tvalid;
  logic                      tready;
  logic                      tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/ethernet_rx_drain_fifo.sv
// Two-entry valid/ready FIFO; the head entry drives the output directly from a register.
//   clk_i, reset_i            : clock, async active-high reset
//   in_valid_i/in_data_i      : write side, in_ready_c_o accepts (may depend on out_ready_i)
//   out_valid_o/out_data_o    : read side, out_ready_i pops
//   count_o                   : registered occupancy (0..2)
module ethernet_rx_drain_fifo #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  input  logic [width_p-1:0] in_data_i,
  output logic               in_ready_c_o,
  output logic               out_valid_o,
  output logic [width_p-1:0] out_data_o,
  input  logic               out_ready_i,
  output logic [1:0]         count_o
);

  logic [width_p-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]         count_q, count_d;
  logic               valid_q;
  logic               push_c, pop_c;

  // Head always holds the oldest entry; tail only used when two are stored.
  always_comb begin
    pop_c        = valid_q && out_ready_i;
    in_ready_c_o = (count_q != 2'd2) || pop_c;
    push_c       = in_valid_i && in_ready_c_o;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    case ({push_c, pop_c})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data_i;
        else                 tail_d = in_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_data_i;
        end else begin
          head_d = tail_q;
          tail_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= (count_d != 2'd0);
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = head_q;
  assign count_o     = count_q;

endmodule

// File: rtl/ethernet_rx_drain.sv
// Drains one received packet at a time from the receive buffer onto a beat stream,
// then releases the buffer slot with a one-cycle clear pulse.
//   clk_i, reset_i                      : clock, async active-high reset
//   rx_ready_i, rx_packet_size_i        : packet available and its byte count
//   buffer_read_*                       : buffer read port, data returns one cycle after v
//   clear_buffer_o                      : slot release pulse
//   m_axis                              : output beat stream (master modport)
//   packet_count_o                      : packets fully streamed (wrapping)
//   runt_count_o                        : runts dropped, only with ETHERNET_RX_DRAIN_RUNT_DROP_EN
// Optional feature macro: ETHERNET_RX_DRAIN_RUNT_DROP_EN drops packets shorter than RUNT_BYTES.
module ethernet_rx_drain
  import ethernet_rx_drain_pkg::*;
#(
  parameter  int unsigned data_width_p  = 64,
  parameter  int unsigned buf_size_p    = 2048,
  localparam int unsigned addr_width_lp = $clog2(buf_size_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     rx_ready_i,
  input  logic [15:0]              rx_packet_size_i,
  output logic                     buffer_read_v_o,
  output logic [addr_width_lp-1:0] buffer_read_addr_o,
  output logic [1:0]               buffer_read_op_size_o,
  input  logic [data_width_p-1:0]  buffer_read_data_i,
  output logic                     clear_buffer_o,
  ethernet_rx_drain_if.master      m_axis,
  output logic [15:0]              packet_count_o
`ifdef ETHERNET_RX_DRAIN_RUNT_DROP_EN
  ,
  output logic [15:0]              runt_count_o
`endif
);

  localparam int unsigned size_width_lp = addr_width_lp + 1;
  localparam int unsigned bpw_lp        = bytes_per_word(data_width_p);
  localparam int unsigned bpw_log_lp    = $clog2(bpw_lp);
  localparam int unsigned beat_width_lp = data_width_p + bpw_lp + 1;
  localparam logic [bpw_lp-1:0] keep_ones_lp = '1;

  state_e                    state_q, state_d;
  logic [addr_width_lp-1:0]  addr_q, addr_d;
  logic [size_width_lp-1:0]  reads_left_q, reads_left_d;
  logic [size_width_lp-1:0]  words_q, words_d;
  logic [size_width_lp-1:0]  push_idx_q, push_idx_d;
  logic [bpw_lp-1:0]         last_keep_q, last_keep_d;
  logic                      rd_pend_q;
  logic                      clear_q;
  logic [15:0]               pkt_count_q, pkt_count_d;
`ifdef ETHERNET_RX_DRAIN_RUNT_DROP_EN
  logic [15:0]               runt_count_q, runt_count_d;
`endif

  logic [15:0]               size_clamped_c;
  logic [size_width_lp-1:0]  size_c, words_c;
  logic [bpw_log_lp-1:0]     rem_c;
  logic [bpw_lp-1:0]         keep_c;
  logic                      issue_c;
  logic [1:0]                occ_c;
  logic                      fifo_pop_c;
  logic                      fifo_in_ready;
  logic                      fifo_valid;
  logic [1:0]                fifo_count;
  logic [beat_width_lp-1:0]  fifo_in_beat, fifo_out_beat;
  logic                      push_last_c;

  // Packet geometry from the (clamped) size presented in IDLE.
  always_comb begin
    size_clamped_c = (rx_packet_size_i > 16'(buf_size_p)) ? 16'(buf_size_p) : rx_packet_size_i;
    size_c         = size_width_lp'(size_clamped_c);
    words_c        = (size_c + size_width_lp'(bpw_lp - 1)) >> bpw_log_lp;
    rem_c          = size_c[bpw_log_lp-1:0];
    keep_c         = (rem_c == '0) ? keep_ones_lp : ~(keep_ones_lp << rem_c);
  end

  // Reads are throttled on occupancy after this cycle's pop plus the read whose data
  // arrives now, so a stalled sink can never overflow the two-entry FIFO.
  always_comb begin
    fifo_pop_c = fifo_valid && m_axis.tready;
    occ_c      = fifo_count - 2'(fifo_pop_c) + 2'(rd_pend_q);
    issue_c    = (state_q == ST_READ) && (reads_left_q != '0) && (occ_c < 2'd2);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    reads_left_d = reads_left_q;
    words_d      = words_q;
    push_idx_d   = rd_pend_q ? push_idx_q + size_width_lp'(1) : push_idx_q;
    last_keep_d  = last_keep_q;
    pkt_count_d  = pkt_count_q;
`ifdef ETHERNET_RX_DRAIN_RUNT_DROP_EN
    runt_count_d = runt_count_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_ready_i) begin
          addr_d       = '0;
          reads_left_d = words_c;
          words_d      = words_c;
          push_idx_d   = '0;
          last_keep_d  = keep_c;
          if (size_c == '0) begin
            state_d = ST_CLEAR;
`ifdef ETHERNET_RX_DRAIN_RUNT_DROP_EN
          end else if (size_c < size_width_lp'(RUNT_BYTES)) begin
            // Empty packets are not runts; only 1..59-byte packets are counted.
            state_d      = ST_CLEAR;
            runt_count_d = runt_count_q + 16'd1;
`endif
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (issue_c) begin
          addr_d       = addr_q + addr_width_lp'(bpw_lp);
          reads_left_d = reads_left_q - size_width_lp'(1);
          if (reads_left_q == size_width_lp'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_pop_c && m_axis.tlast) begin
          state_d     = ST_CLEAR;
          pkt_count_d = pkt_count_q + 16'd1;
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      reads_left_q <= '0;
      words_q      <= '0;
      push_idx_q   <= '0;
      last_keep_q  <= '0;
      rd_pend_q    <= 1'b0;
      clear_q      <= 1'b0;
      pkt_count_q  <= '0;
`ifdef ETHERNET_RX_DRAIN_RUNT_DROP_EN
      runt_count_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      reads_left_q <= reads_left_d;
      words_q      <= words_d;
      push_idx_q   <= push_idx_d;
      last_keep_q  <= last_keep_d;
      rd_pend_q    <= issue_c;
      clear_q      <= (state_d == ST_CLEAR);
      pkt_count_q  <= pkt_count_d;
`ifdef ETHERNET_RX_DRAIN_RUNT_DROP_EN
      runt_count_q <= runt_count_d;
`endif
    end
  end

  // Beat tagging happens as buffer data lands, one cycle after the read.
  always_comb begin
    push_last_c  = (push_idx_q == words_q - size_width_lp'(1));
    fifo_in_beat = {push_last_c, push_last_c ? last_keep_q : keep_ones_lp, buffer_read_data_i};
  end

  ethernet_rx_drain_fifo #(.width_p(beat_width_lp)) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (rd_pend_q),
    .in_data_i   (fifo_in_beat),
    .in_ready_c_o(fifo_in_ready),
    .out_valid_o (fifo_valid),
    .out_data_o  (fifo_out_beat),
    .out_ready_i (m_axis.tready),
    .count_o     (fifo_count)
  );

  assign m_axis.tvalid         = fifo_valid;
  assign m_axis.tdata          = fifo_out_beat[data_width_p-1:0];
  assign m_axis.tkeep          = fifo_out_beat[data_width_p +: bpw_lp];
  assign m_axis.tlast          = fifo_out_beat[beat_width_lp-1];
  assign buffer_read_v_o       = issue_c;
  assign buffer_read_addr_o    = addr_q;
  assign buffer_read_op_size_o = 2'(bpw_log_lp);
  assign clear_buffer_o        = clear_q;
  assign packet_count_o        = pkt_count_q;
`ifdef ETHERNET_RX_DRAIN_RUNT_DROP_EN
  assign runt_count_o          = runt_count_q;
`endif

`ifndef SYNTHESIS
  // The receiver must keep its packet presented until the slot is released.
  a_rx_ready_held: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == ST_READ || state_q == ST_DRAIN) |-> rx_ready_i)
    else $error("ethernet_rx_drain: rx_ready_i dropped mid-packet");

  a_fifo_accepts: assert property (@(posedge clk_i) disable iff (reset_i)
    rd_pend_q |-> fifo_in_ready)
    else $error("ethernet_rx_drain: buffer data arrived with output FIFO full");
`endif

endmodule

// File: tb/tb_ethernet_rx_drain.sv
module tb_ethernet_rx_drain;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        rx_ready_i;
  logic [15:0] rx_packet_size_i;
  logic        buffer_read_v_o;
  logic [10:0] buffer_read_addr_o;
  logic [1:0]  buffer_read_op_size_o;
  logic [63:0] buffer_read_data_i;
  logic        clear_buffer_o;
  logic [15:0] packet_count_o;
`ifdef ETHERNET_RX_DRAIN_RUNT_DROP_EN
  logic [15:0] runt_count_o;
`endif

  ethernet_rx_drain_if #(.data_width_p(64)) axis ();

  ethernet_rx_drain #(.data_width_p(64), .buf_size_p(2048)) dut (
    .clk_i                (clk),
    .reset_i              (reset_i),
    .rx_ready_i           (rx_ready_i),
    .rx_packet_size_i     (rx_packet_size_i),
    .buffer_read_v_o      (buffer_read_v_o),
    .buffer_read_addr_o   (buffer_read_addr_o),
    .buffer_read_op_size_o(buffer_read_op_size_o),
    .buffer_read_data_i   (buffer_read_data_i),
    .clear_buffer_o       (clear_buffer_o),
    .m_axis               (axis),
    .packet_count_o       (packet_count_o)
`ifdef ETHERNET_RX_DRAIN_RUNT_DROP_EN
    ,
    .runt_count_o         (runt_count_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] pkt_tag = 8'h00;
  int exp_words = 0;
  beat_t sb[$];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [7:0] tag, input logic [10:0] addr);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(addr + 11'(k)) ^ tag;
    return w;
  endfunction

  // Buffer model: data is returned exactly one cycle after the read request.
  always @(posedge clk) begin
    if (buffer_read_v_o) buffer_read_data_i <= mem_word(pkt_tag, buffer_read_addr_o);
    else                 buffer_read_data_i <= '0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor and scoreboard consumer.
  int    beats = 0, first_cyc = 0, last_cyc = 0, rd_in_pkt = 0, issued = 0, popped = 0;
  logic  hold = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    beat_t exp_b;
    if (reset_i) begin
      beats = 0; rd_in_pkt = 0; issued = 0; popped = 0; hold = 1'b0;
    end else begin
      if (hold)
        chk("stall_stable", 80'({axis.tvalid, axis.tdata, axis.tkeep, axis.tlast}),
            80'({1'b1, held}));
      if (buffer_read_v_o) begin
        chk("rd_addr", 80'(buffer_read_addr_o), 80'(rd_in_pkt * 8));
        rd_in_pkt++;
        issued++;
      end
      if (axis.tvalid && axis.tready) begin
        popped++;
        chk("sb_has_entry", 80'(sb.size() != 0), 80'(1));
        exp_b = (sb.size() != 0) ? sb.pop_front() : '0;
        chk("tdata", 80'(axis.tdata), 80'(exp_b.data));
        chk("tkeep", 80'(axis.tkeep), 80'(exp_b.keep));
        chk("tlast", 80'(axis.tlast), 80'(exp_b.last));
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      if (buffer_read_v_o)
        chk("outstanding_le2", 80'((issued - popped) <= 2), 80'(1));
      hold = axis.tvalid && !axis.tready;
      held = {axis.tdata, axis.tkeep, axis.tlast};
      if (clear_buffer_o) begin
        beats = 0;
        rd_in_pkt = 0;
      end
    end
  end

  // Present one packet, wait for the clear pulse, then check totals.
  task automatic run_packet(input int size, input logic [7:0] tag, input bit toggle,
                            input int exp_pkt, input bit streamed);
    int    eff, words, rem, n;
    bit    seen;
    beat_t b;
    eff   = (size > 2048) ? 2048 : size;
    words = streamed ? (eff + 7) / 8 : 0;
    rem   = eff % 8;
    pkt_tag   = tag;
    exp_words = words;
    for (int i = 0; i < words; i++) begin
      b.data = mem_word(tag, 11'(i * 8));
      b.last = (i == words - 1);
      b.keep = (b.last && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
      sb.push_back(b);
    end
    @(posedge clk); #1;
    rx_ready_i       = 1'b1;
    rx_packet_size_i = 16'(size);
    axis.tready      = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (toggle) axis.tready = ~axis.tready;
      if (clear_buffer_o) seen = 1'b1;
    end
    chk("clear_seen", 80'(seen), 80'(1));
    if (size == 0) chk("clear_latency", 80'(n), 80'(1));
    rx_ready_i  = 1'b0;
    axis.tready = 1'b1;
    chk("beat_count", 80'(beats), 80'(words));
    chk("sb_empty", 80'(sb.size()), 80'(0));
    chk("packet_count", 80'(packet_count_o), 80'(exp_pkt));
    if (!toggle && words > 0)
      chk("throughput", 80'(last_cyc - first_cyc), 80'(words - 1));
    sb.delete();
    @(posedge clk); #1;
    chk("clear_one_cycle", 80'(clear_buffer_o), 80'(0));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tvalid", 80'(axis.tvalid), 80'(0));
    chk("rst_tlast", 80'(axis.tlast), 80'(0));
    chk("rst_tdata", 80'(axis.tdata), 80'(0));
    chk("rst_tkeep", 80'(axis.tkeep), 80'(0));
    chk("rst_read_v", 80'(buffer_read_v_o), 80'(0));
    chk("rst_clear", 80'(clear_buffer_o), 80'(0));
    chk("rst_pkt_count", 80'(packet_count_o), 80'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset_i          = 1'b1;
    rx_ready_i       = 1'b0;
    rx_packet_size_i = 16'd0;
    axis.tready      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    chk("op_size", 80'(buffer_read_op_size_o), 80'(3));
    @(posedge clk); #1;
    reset_i = 1'b0;

    run_packet(64,   8'h11, 1'b0, 1, 1'b1);
    run_packet(61,   8'h22, 1'b0, 2, 1'b1);
    run_packet(128,  8'h33, 1'b1, 3, 1'b1);
    run_packet(0,    8'h44, 1'b0, 3, 1'b0);
    run_packet(2100, 8'h55, 1'b0, 4, 1'b1);
`ifdef ETHERNET_RX_DRAIN_RUNT_DROP_EN
    run_packet(40,   8'h66, 1'b0, 4, 1'b0);
    chk("runt_count", 80'(runt_count_o), 80'(1));
`else
    run_packet(20,   8'h66, 1'b0, 5, 1'b1);
`endif

    // Reset while beat 3 of a 64-byte packet is on the stream.
    pkt_tag = 8'h77;
    for (int i = 0; i < 8; i++) begin
      beat_t b;
      b.data = mem_word(8'h77, 11'(i * 8));
      b.last = (i == 7);
      b.keep = 8'hFF;
      sb.push_back(b);
    end
    @(posedge clk); #1;
    rx_ready_i       = 1'b1;
    rx_packet_size_i = 16'd64;
    n = 0;
    while (beats < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beats_before_reset", 80'(beats), 80'(2));
    chk("beat3_presented", 80'(axis.tvalid), 80'(1));
    reset_i    = 1'b1;
    rx_ready_i = 1'b0;
    sb.delete();
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    reset_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_clear_after_reset", 80'(clear_buffer_o), 80'(0));
    end
    run_packet(64, 8'h88, 1'b0, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
